// File: rtl/fifo_uart_tx.sv
// Byte-FIFO-fed UART transmitter: pulls one byte per frame from an upstream FIFO, sends 8N1 LSB first.
// Optional even parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  output logic       fifo_rd,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_valid,
  input  logic       fifo_empty,
  output logic       tx,
  output logic       busy,
  output logic [2:0] state_dbg
);

  // FIFO handshake: fifo_rd is a single-cycle strobe issued from IDLE; the FIFO answers with
  // fifo_valid/fifo_dout exactly one cycle later (sampled in WAIT). No valid means no byte.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_end;

  assign bit_end   = (baud_cnt == 16'(CLKS_PER_BIT - 1));
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // tx is loaded with the level of the state being entered, so it changes on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      fifo_rd  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      fifo_rd <= 1'b0;
      case (state)
        S_IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) begin
            fifo_rd <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (fifo_valid) begin
            shreg <= fifo_dout;
            tx    <= 1'b0;
            state <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
          if (bit_end) begin
            tx      <= shreg[0];
            bit_idx <= 3'd0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= ^shreg;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        S_PARITY: begin
          baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
          if (bit_end) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
          if (bit_end) state <= S_IDLE;
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port fifo_rd  output  1  read strobe to upstream byte FIFO, registered.
REQ-005 SHALL have port fifo_dout  input  8  FIFO read data.
REQ-006 SHALL have port fifo_valid  input  1  FIFO read data valid, one cycle after fifo_rd.
REQ-007 SHALL have port fifo_empty  input  1  FIFO holds no bytes.
REQ-008 SHALL have port tx  output  1  UART serial line, idle high, registered.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, REQ, WAIT, START, DATA, [PARITY], STOP.
REQ-011 IDLE: when fifo_empty low -> fifo_rd high for exactly the next cycle, state REQ; else remain, tx high.
REQ-012 REQ: fifo_rd high this cycle only; next state WAIT unconditionally.
REQ-013 WAIT: fifo_valid high -> latch fifo_dout into shift register, next state START; fifo_valid low -> IDLE, no frame, no second read.
REQ-014 START: tx low for CLKS_PER_BIT cycles, first low cycle is the cycle after fifo_valid was sampled.
REQ-015 DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles; 3-bit bit index, no wrap past 7.
REQ-016 STOP: tx high for CLKS_PER_BIT cycles, then IDLE.
REQ-017 Frame length SHALL be 10*CLKS_PER_BIT cycles (11* with parity); baud counter wraps to 0 at CLKS_PER_BIT-1.
REQ-018 fifo_rd SHALL never assert outside IDLE->REQ; at most one read per frame; never while fifo_empty sampled high.
REQ-019 Back-to-back: FIFO non-empty at STOP end -> IDLE one cycle, fifo_rd next; inter-frame idle-high gap exactly 3 cycles.
REQ-020 fifo_dout changes outside WAIT SHALL not affect the frame in flight.
REQ-021 busy SHALL be high in REQ through last STOP cycle, low in IDLE.

Reset
REQ-022 rst high at a rising edge -> state IDLE, tx=1, fifo_rd=0, busy=0, counters and shift register 0 on the following cycle.
REQ-023 rst mid-frame SHALL abort the frame; byte discarded, no re-read.
REQ-024 During rst, fifo_rd SHALL stay 0 regardless of fifo_empty.

Configuration
REQ-025 Macro FIFO_UART_TX_PARITY_EN defined -> PARITY state between DATA and STOP, tx = even parity (XOR of 8 data bits) for CLKS_PER_BIT cycles.
REQ-026 Macro undefined -> no PARITY state, DATA goes directly to STOP, 10-bit frame.

Verification (CLKS_PER_BIT=4 on bench)
REQ-027 FIFO pre-loaded 0xA5, release rst -> fifo_rd one pulse, tx: 0 x4, 1,0,1,0,0,1,0,1 x4 each, 1 x4; busy low after.
REQ-028 FIFO empty 100 cycles after reset -> fifo_rd never high, tx constant 1, busy 0.
REQ-029 FIFO loaded 0x01..0x0C (12 bytes) -> 12 frames decoded in order, 3-cycle gaps, exactly 12 fifo_rd pulses.
REQ-030 rst asserted at cycle 15 of frame 0x3C -> tx=1 next cycle, byte 0x3C never completes, next frame is following FIFO byte.
REQ-031 fifo_valid held low after fifo_rd -> return to IDLE, no start bit, retry next IDLE cycle.
REQ-032 With FIFO_UART_TX_PARITY_EN, bytes 0x07 and 0x03 -> parity bits 1 and 0, frame 44 cycles.
